tx_mac_arbiter: RTL and testbench



---
 rtl/tx_mac_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_tx_mac_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_mac_arbiter.sv
// tx_mac_arbiter: packet-level round-robin arbiter that shares the single
// 64-bit 10G MAC transmit AXI-Stream (clk156) between NUM_PORTS requesters.
// A grant covers a whole frame. Frames longer than MAX_BEATS are cut short:
// tlast is forced on beat MAX_BEATS and the remainder is drained from the
// source.
// Optional build macro TX_ARB_PRIO0_EN: port 0 gets strict priority, and the
// remaining ports round-robin among themselves.
module tx_mac_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_BEATS = 190
) (
  input  logic                      clk156,
  input  logic                      reset,
  input  logic [NUM_PORTS*64-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*8-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]      s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]      s_axis_tlast,
  output logic [NUM_PORTS-1:0]      s_axis_tready,
  output logic [63:0]               m_axis_tdata,
  output logic [7:0]                m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [NUM_PORTS-1:0]      grant,
  output logic                      trunc_pulse,
  output logic [15:0]               trunc_count
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [15:0]        beat_cnt_q, beat_cnt_d;
  logic [15:0]        trunc_count_q, trunc_count_d;
  logic               trunc_pulse_q, trunc_pulse_d;

  // Arbitration and granted-source view
  int unsigned        last_u;
  int unsigned        gidx_u;
  int unsigned        cand;
  logic [IDX_W-1:0]   cand_idx;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  logic               src_valid;
  logic               src_last;
  logic [63:0]        src_data;
  logic [7:0]         src_keep;
  logic               at_limit;
  logic               pass_hs;
  logic               drop_hs;
  logic               trunc_ev;

  assign last_u = {{(32-IDX_W){1'b0}}, last_grant_q};
  assign gidx_u = {{(32-IDX_W){1'b0}}, gidx_q};

  // Select the next owner, searching upward from the previous owner with wrap
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
`ifdef TX_ARB_PRIO0_EN
    // last_grant only ever holds 1..NUM_PORTS-1 here, so the rotation runs
    // over that sub-range and port 0 is handled ahead of it.
    if (s_axis_tvalid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end else begin
      for (int unsigned k = 1; k < NUM_PORTS; k++) begin
        cand     = ((last_u - 1 + k) % (NUM_PORTS - 1)) + 1;
        cand_idx = cand[IDX_W-1:0];
        if (!win_found && s_axis_tvalid[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
`else
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand     = (last_u + k) % NUM_PORTS;
      cand_idx = cand[IDX_W-1:0];
      if (!win_found && s_axis_tvalid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
`endif
  end

  // Pick out the granted requester's lane and classify this cycle's transfer
  always_comb begin
    src_valid = s_axis_tvalid[gidx_q];
    src_last  = s_axis_tlast[gidx_q];
    src_data  = s_axis_tdata[gidx_u*64 +: 64];
    src_keep  = s_axis_tkeep[gidx_u*8 +: 8];
    at_limit  = (beat_cnt_q == 16'(MAX_BEATS - 1));
    pass_hs   = (state_q == ST_PASS) && src_valid && m_axis_tready;
    drop_hs   = (state_q == ST_DROP) && src_valid;
    trunc_ev  = pass_hs && !src_last && at_limit;
  end

  // State register
  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) state_d = ST_PASS;
      end
      ST_PASS: begin
        if (pass_hs && src_last) state_d = ST_IDLE;
        else if (trunc_ev)       state_d = ST_DROP;
      end
      ST_DROP: begin
        if (drop_hs && src_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: zero-latency mux from the owner in PASS, drain in DROP
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      ST_PASS: begin
        m_axis_tdata          = src_data;
        m_axis_tkeep          = src_keep;
        m_axis_tvalid         = src_valid;
        // The limit beat always closes the frame on the MAC side
        m_axis_tlast          = src_last || at_limit;
        s_axis_tready[gidx_q] = m_axis_tready;
      end
      ST_DROP: begin
        s_axis_tready[gidx_q] = 1'b1;
      end
      default: ;
    endcase
    grant       = grant_q;
    trunc_pulse = trunc_pulse_q;
    trunc_count = trunc_count_q;
  end

  // Grant, round-robin pointer, beat counter and truncation statistics
  always_comb begin
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    trunc_pulse_d = trunc_ev;
    trunc_count_d = trunc_count_q;

    if (state_q == ST_IDLE && win_found) begin
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      gidx_d           = win_idx;
      beat_cnt_d       = '0;
`ifdef TX_ARB_PRIO0_EN
      if (win_idx != '0) last_grant_d = win_idx;
`else
      last_grant_d     = win_idx;
`endif
    end

    if (pass_hs) beat_cnt_d = beat_cnt_q + 16'd1;

    if ((pass_hs || drop_hs) && src_last) grant_d = '0;

    if (trunc_ev && trunc_count_q != 16'hFFFF) trunc_count_d = trunc_count_q + 16'd1;
  end

  // Datapath registers
  always_ff @(posedge clk156) begin
    if (reset) begin
      grant_q       <= '0;
      gidx_q        <= '0;
      last_grant_q  <= IDX_W'(NUM_PORTS - 1);
      beat_cnt_q    <= '0;
      trunc_pulse_q <= 1'b0;
      trunc_count_q <= '0;
    end else begin
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      trunc_pulse_q <= trunc_pulse_d;
      trunc_count_q <= trunc_count_d;
    end
  end

endmodule

// File: tb/tb_tx_mac_arbiter.sv
// Directed testbench for tx_mac_arbiter. Two instances share the requester
// inputs: dut (MAX_BEATS=190) and dut_t (MAX_BEATS=4, truncation cases).
// Requester frames are modelled per port; beat data encodes
// {port, frames_left, 16'hBEEF, beat}.
module tb_tx_mac_arbiter;

  logic         clk156 = 1'b0;
  logic         reset;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tlast;
  logic         m_tready;

  logic [3:0]   s_tready,    s_tready_t;
  logic [63:0]  m_tdata,     m_tdata_t;
  logic [7:0]   m_tkeep,     m_tkeep_t;
  logic         m_tvalid,    m_tvalid_t;
  logic         m_tlast,     m_tlast_t;
  logic [3:0]   grant,       grant_t;
  logic         trunc_pulse, trunc_pulse_t;
  logic [15:0]  trunc_count, trunc_count_t;

  always #5 clk156 = ~clk156;

  tx_mac_arbiter #(.NUM_PORTS(4), .MAX_BEATS(190)) dut (
    .clk156(clk156), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant(grant), .trunc_pulse(trunc_pulse), .trunc_count(trunc_count)
  );

  tx_mac_arbiter #(.NUM_PORTS(4), .MAX_BEATS(4)) dut_t (
    .clk156(clk156), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready_t),
    .m_axis_tdata(m_tdata_t), .m_axis_tkeep(m_tkeep_t), .m_axis_tvalid(m_tvalid_t),
    .m_axis_tlast(m_tlast_t), .m_axis_tready(m_tready),
    .grant(grant_t), .trunc_pulse(trunc_pulse_t), .trunc_count(trunc_count_t)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  bit use_t;

  int fl[4];
  int ln[4];
  int bt[4];
  bit en[4];

  int          cap_cyc[$];
  logic [63:0] cap_data[$];
  logic        cap_last[$];
  logic [7:0]  cap_keep[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input int p, input int f, input int b);
    return {16'(p), 16'(f), 16'hBEEF, 16'(b)};
  endfunction

  task automatic apply();
    for (int p = 0; p < 4; p++) begin
      s_tvalid[p]        = en[p] && (fl[p] > 0);
      s_tlast[p]         = (bt[p] == ln[p] - 1);
      s_tdata[p*64 +: 64] = beat_word(p, fl[p], bt[p]);
      s_tkeep[p*8 +: 8]  = s_tlast[p] ? 8'h0F : 8'hFF;
    end
    #1;
  endtask

  task automatic clear_model();
    for (int p = 0; p < 4; p++) begin
      fl[p] = 0; ln[p] = 1; bt[p] = 0; en[p] = 1'b1;
    end
    cap_cyc.delete(); cap_data.delete(); cap_last.delete(); cap_keep.delete();
    cyc = 0;
  endtask

  // Sample handshakes just before the edge, then advance sources after it
  task automatic cycle();
    logic [3:0] tr;
    bit hs[4];
    tr = use_t ? s_tready_t : s_tready;
    for (int p = 0; p < 4; p++) hs[p] = s_tvalid[p] && tr[p];
    if (use_t ? (m_tvalid_t && m_tready) : (m_tvalid && m_tready)) begin
      cap_cyc.push_back(cyc);
      cap_data.push_back(use_t ? m_tdata_t : m_tdata);
      cap_last.push_back(use_t ? m_tlast_t : m_tlast);
      cap_keep.push_back(use_t ? m_tkeep_t : m_tkeep);
    end
    @(posedge clk156);
    #1;
    cyc++;
    for (int p = 0; p < 4; p++) begin
      if (hs[p]) begin
        if (bt[p] == ln[p] - 1) begin
          bt[p] = 0;
          fl[p] = fl[p] - 1;
        end else begin
          bt[p] = bt[p] + 1;
        end
      end
    end
    apply();
  endtask

  task automatic chk_beat(input string tag, input int i, input int ecyc,
                          input logic [63:0] edata, input logic elast);
    if (i < cap_data.size()) begin
      chk($sformatf("%s_cyc%0d", tag, i), 64'(cap_cyc[i]), 64'(ecyc));
      chk($sformatf("%s_data%0d", tag, i), cap_data[i], edata);
      chk($sformatf("%s_last%0d", tag, i), 64'(cap_last[i]), 64'(elast));
    end
  endtask

  initial begin
    int ep[8];
    int ef[8];
    int ec[8];
    logic [3:0] eg;

    use_t = 1'b0;
    reset = 1'b1;
    m_tready = 1'b1;
    clear_model();
    apply();
    cycle();
    cycle();

    // Reset state
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_mvalid", 64'(m_tvalid), 64'h0);
    chk("rst_sready", 64'(s_tready), 64'h0);
    chk("rst_tpulse", 64'(trunc_pulse), 64'h0);
    chk("rst_tcount", 64'(trunc_count), 64'h0);
    reset = 1'b0;
    apply();

    // Four requesters with one 4-beat frame each, all valid together
    clear_model();
    for (int p = 0; p < 4; p++) begin fl[p] = 1; ln[p] = 4; end
    apply();
    for (int c = 0; c <= 20; c++) begin
      eg = 4'b0000;
      if (c >= 1 && ((c - 1) % 5) < 4 && ((c - 1) / 5) < 4) eg = 4'(1 << ((c - 1) / 5));
      chk($sformatf("t1_grant_c%0d", c), 64'(grant), 64'(eg));
      cycle();
    end
    chk("t1_nbeats", 64'(cap_data.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk_beat("t1", i, 1 + 5 * (i / 4) + (i % 4), beat_word(i / 4, 1, i % 4), (i % 4) == 3);
    if (cap_keep.size() > 3) chk("t1_keep_last", 64'(cap_keep[3]), 64'h0F);
    if (cap_keep.size() > 0) chk("t1_keep_first", 64'(cap_keep[0]), 64'hFF);

    // Port 2 sends 8 beats; port 1 raises valid mid-frame and must wait
    clear_model();
    fl[2] = 1; ln[2] = 8;
    fl[1] = 1; ln[1] = 2; en[1] = 1'b0;
    apply();
    for (int c = 0; c <= 12; c++) begin
      if (c == 3) begin en[1] = 1'b1; apply(); end
      eg = 4'b0000;
      if (c >= 1 && c <= 8) eg = 4'b0100;
      if (c >= 10 && c <= 11) eg = 4'b0010;
      chk($sformatf("t2_grant_c%0d", c), 64'(grant), 64'(eg));
      cycle();
    end
    chk("t2_nbeats", 64'(cap_data.size()), 64'd10);
    for (int i = 0; i < 8; i++) chk_beat("t2p2", i, 1 + i, beat_word(2, 1, i), i == 7);
    for (int i = 0; i < 2; i++) chk_beat("t2p1", 8 + i, 10 + i, beat_word(1, 1, i), i == 1);

    // Master ready toggling during a 6-beat frame from port 3
    clear_model();
    fl[3] = 1; ln[3] = 6;
    apply();
    for (int c = 0; c <= 12; c++) begin
      m_tready = (c % 2 == 1);
      apply();
      if (c >= 1 && c <= 11)
        chk($sformatf("t4_mirror_c%0d", c), 64'(s_tready), 64'({m_tready, 3'b000}));
      cycle();
    end
    m_tready = 1'b1;
    apply();
    chk("t4_grant_end", 64'(grant), 64'h0);
    chk("t4_nbeats", 64'(cap_data.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk_beat("t4", i, 1 + 2 * i, beat_word(3, 1, i), i == 5);

    // Ports 0 and 3 continuously valid with 2-beat frames
    clear_model();
    fl[0] = 2; ln[0] = 2; fl[3] = 2; ln[3] = 2;
    apply();
`ifdef TX_ARB_PRIO0_EN
    ep = '{0, 0, 0, 0, 3, 3, 3, 3};
    ef = '{2, 2, 1, 1, 2, 2, 1, 1};
`else
    ep = '{0, 0, 3, 3, 0, 0, 3, 3};
    ef = '{2, 2, 2, 2, 1, 1, 1, 1};
`endif
    ec = '{1, 2, 4, 5, 7, 8, 10, 11};
    for (int c = 0; c <= 12; c++) cycle();
    chk("t5_nbeats", 64'(cap_data.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_beat("t5", i, ec[i], beat_word(ep[i], ef[i], i % 2), (i % 2) == 1);

    // Truncation on dut_t (MAX_BEATS=4): 7-beat frame from port 0
    reset = 1'b1;
    clear_model();
    apply();
    cycle();
    cycle();
    reset = 1'b0;
    use_t = 1'b1;
    clear_model();
    fl[0] = 1; ln[0] = 7;
    apply();
    for (int c = 0; c <= 8; c++) begin
      if (c >= 1 && c <= 7) chk($sformatf("t3_grant_c%0d", c), 64'(grant_t), 64'h1);
      if (c == 8) chk("t3_grant_idle", 64'(grant_t), 64'h0);
      if (c == 4 || c == 6) chk($sformatf("t3_nopulse_c%0d", c), 64'(trunc_pulse_t), 64'h0);
      if (c == 5) begin
        chk("t3_pulse", 64'(trunc_pulse_t), 64'h1);
        chk("t3_count", 64'(trunc_count_t), 64'h1);
      end
      if (c >= 5 && c <= 7) begin
        chk($sformatf("t3_mvalid_c%0d", c), 64'(m_tvalid_t), 64'h0);
        chk($sformatf("t3_sready_c%0d", c), 64'(s_tready_t), 64'h1);
      end
      cycle();
    end
    chk("t3_nbeats", 64'(cap_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_beat("t3", i, 1 + i, beat_word(0, 1, i), i == 3);

    // Exactly MAX_BEATS beats with source tlast is a legal frame
    clear_model();
    fl[0] = 1; ln[0] = 4;
    apply();
    for (int c = 0; c <= 6; c++) begin
      if (c == 5) begin
        chk("t3b_nopulse", 64'(trunc_pulse_t), 64'h0);
        chk("t3b_count", 64'(trunc_count_t), 64'h1);
        chk("t3b_grant", 64'(grant_t), 64'h0);
      end
      cycle();
    end
    chk("t3b_nbeats", 64'(cap_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_beat("t3b", i, 1 + i, beat_word(0, 1, i), i == 3);

    // Reset on beat 2 of a 5-beat frame from port 2
    use_t = 1'b0;
    clear_model();
    fl[2] = 1; ln[2] = 5;
    apply();
    for (int c = 0; c <= 6; c++) begin
      if (c == 2) begin
        chk("t6_grant_pre", 64'(grant), 64'h4);
        reset = 1'b1;
        apply();
      end
      if (c == 3) begin
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin fl[p] = 0; bt[p] = 0; ln[p] = 1; end
        fl[0] = 1; ln[0] = 2; fl[2] = 1; ln[2] = 2;
        apply();
        chk("t6_grant_rst", 64'(grant), 64'h0);
        chk("t6_mvalid_rst", 64'(m_tvalid), 64'h0);
        chk("t6_sready_rst", 64'(s_tready), 64'h0);
        chk("t6_tcount_rst", 64'(trunc_count_t), 64'h0);
      end
      if (c == 4) chk("t6_grant_after", 64'(grant), 64'h1);
      cycle();
    end
    chk("t6_nbeats", 64'(cap_data.size()), 64'd4);
    chk_beat("t6a", 0, 1, beat_word(2, 1, 0), 1'b0);
    chk_beat("t6a", 1, 2, beat_word(2, 1, 1), 1'b0);
    chk_beat("t6b", 2, 4, beat_word(0, 1, 0), 1'b0);
    chk_beat("t6b", 3, 5, beat_word(0, 1, 1), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
